// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART serializer among N_REQ byte producers, with packet lock.
// Optional macro HOLD_TIMEOUT_EN drops a stalled packet lock after HOLD_TIMEOUT cycles.
//
// state | meaning
// IDLE  | no grant active; round-robin winner may transfer a byte
// START | one-cycle start strobe to the serializer
// WAIT  | serializer busy; waiting for its done tick
// HOLD  | packet lock held; only the granted requester may transfer
module uart_tx_arbiter #(
    parameter int N_REQ        = 4,
    parameter int GRANT_W      = 2,
    parameter int HOLD_TIMEOUT = 1000000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [8*N_REQ-1:0]   req_data,
    input  logic [N_REQ-1:0]     req_last,
    output logic [N_REQ-1:0]     req_ready,
    output logic                 tx_start,
    output logic [7:0]           tx_byte,
    input  logic                 tx_done_tick,
    output logic                 busy,
    output logic [GRANT_W-1:0]   grant_id,
    output logic                 timeout_err
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] HOLD  = 2'd3;

    logic [1:0]         state;
    logic               lock;
    logic [GRANT_W-1:0] rr_ptr;
    logic               win_found;
    logic [GRANT_W-1:0] win_id;
    logic [GRANT_W-1:0] sel_id;
    logic [7:0]         sel_data;
    logic               sel_last;
    logic               xfer;
    logic               hold_expire;
    logic [GRANT_W-1:0] ptr_after_grant;

    // Scan downward so the candidate closest to rr_ptr is the last one written.
    always_comb begin
        int idx;
        idx       = 0;
        win_found = 1'b0;
        win_id    = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = (int'(rr_ptr) + k) % N_REQ;
            if (req_valid[idx]) begin
                win_found = 1'b1;
                win_id    = GRANT_W'(idx);
            end
        end
    end

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (state == IDLE && win_found && win_id == GRANT_W'(i))
                req_ready[i] = 1'b1;
            if (state == HOLD && grant_id == GRANT_W'(i))
                req_ready[i] = req_valid[i];
        end
    end

    assign sel_id = (state == HOLD) ? grant_id : win_id;

    always_comb begin
        sel_data = '0;
        sel_last = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (sel_id == GRANT_W'(i)) begin
                sel_data = req_data[8*i +: 8];
                sel_last = req_last[i];
            end
        end
    end

    assign xfer            = |req_ready;
    assign ptr_after_grant = (grant_id == GRANT_W'(N_REQ - 1)) ? '0 : grant_id + GRANT_W'(1);
    assign tx_start        = (state == START);
    assign busy            = (state != IDLE);

`ifdef HOLD_TIMEOUT_EN
    logic [23:0] hold_cnt;

    // A transfer in the expiry cycle keeps the lock alive.
    assign hold_expire = (state == HOLD) && !xfer && (hold_cnt == 24'(HOLD_TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            hold_cnt    <= '0;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= hold_expire;
            if (state == WAIT && tx_done_tick && lock)
                hold_cnt <= '0;
            else if (state == HOLD)
                hold_cnt <= hold_cnt + 24'd1;
        end
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^HOLD_TIMEOUT;
    assign hold_expire        = 1'b0;
    assign timeout_err        = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            tx_byte  <= '0;
            grant_id <= '0;
            lock     <= 1'b0;
            rr_ptr   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (xfer) begin
                        tx_byte  <= sel_data;
                        grant_id <= win_id;
                        lock     <= ~sel_last;
                        state    <= START;
                    end
                end
                START: state <= WAIT;
                WAIT: begin
                    if (tx_done_tick) begin
                        if (lock) begin
                            state <= HOLD;
                        end else begin
                            rr_ptr <= ptr_after_grant;
                            state  <= IDLE;
                        end
                    end
                end
                HOLD: begin
                    if (xfer) begin
                        tx_byte <= sel_data;
                        lock    <= ~sel_last;
                        state   <= START;
                    end else if (hold_expire) begin
                        lock   <= 1'b0;
                        rr_ptr <= ptr_after_grant;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one uart_tx serializer among N_REQ byte producers, for example the inference result reporter, a debug dump and a status beacon.
- Round-robin arbitration with a per-requester valid/ready byte handshake.
- Packet lock: a requester keeps the grant until it presents a byte flagged last, so multi-byte frames are never interleaved.
- Drives the serializer's start strobe and data byte, and sequences on its done tick.

Parameters:
N_REQ, 4, number of requesters (2..8)
GRANT_W, 2, width of grant_id; must be at least clog2(N_REQ)
HOLD_TIMEOUT, 1000000, clock cycles a locked requester may stall between bytes (used only with HOLD_TIMEOUT_EN)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
req_valid  in  N_REQ  requester i has a byte on req_data
req_data  in  8*N_REQ  byte for requester i, in bits [8i+7:8i]
req_last  in  N_REQ  byte of requester i ends its packet
req_ready  out  N_REQ  byte of requester i accepted this cycle when valid&ready
tx_start  out  1  one-cycle start strobe to the serializer
tx_byte  out  8  byte to the serializer; stable from tx_start until tx_done_tick
tx_done_tick  in  1  serializer finished the stop bit
busy  out  1  high in any state other than IDLE
grant_id  out  GRANT_W  current or most recent granted requester
timeout_err  out  1  one-cycle pulse when a lock is dropped on timeout

Behaviour:
- Reset values: state=IDLE, tx_start=0, tx_byte=0, req_ready=0, grant_id=0, busy=0, timeout_err=0, lock=0, rr_ptr=0.
- Reset has priority over all other activity, including mid-byte. The serializer must be reset by the same event.
- States: IDLE, START, WAIT, HOLD.
- IDLE:
  - Winner is the first i with req_valid[i]=1, scanning rr_ptr, rr_ptr+1, ... modulo N_REQ.
  - req_ready[winner]=1 combinationally; all other req_ready bits are 0.
  - On the transfer edge: tx_byte<=data, grant_id<=winner, lock<=~req_last[winner], state->START.
- START:
  - tx_start=1 for exactly this one cycle; state->WAIT.
  - Accept-to-start latency is 1 cycle.
- WAIT:
  - req_ready=0 for all requesters; tx_byte is held.
  - On tx_done_tick: if lock, state->HOLD; else rr_ptr<=grant_id+1 (wraps to 0 after N_REQ-1) and state->IDLE.
- HOLD:
  - req_ready[grant_id]=req_valid[grant_id]=1 only for the granted requester; every other requester is blocked.
  - On transfer: tx_byte<=data, lock<=~req_last, state->START.
- Throughput: the earliest next acceptance is the cycle after tx_done_tick, so there are no dead bytes between back-to-back transfers.
- tx_done_tick outside WAIT is ignored.
- req_valid may deassert before ready without loss; a valid requester is not required to hold its data after acceptance.
- Only one req_ready bit is ever high.
- Requests from non-granted requesters are ignored in HOLD, with no starvation of the locked requester.

Optional Feature:
- Macro HOLD_TIMEOUT_EN.
- Defined:
  - A 24-bit counter clears on entry to HOLD and increments each cycle in HOLD.
  - When it reaches HOLD_TIMEOUT-1 with no transfer: timeout_err pulses 1 cycle, lock<=0, rr_ptr<=grant_id+1, state->IDLE.
  - A transfer in the same cycle as expiry wins; no error is raised.
- Undefined: HOLD waits indefinitely and timeout_err is tied to 0.

Test Plan:
1. Single-byte arbitration: after reset, req_valid=4'b0001, data0=8'h41, last=1 -> req_ready[0] high in that cycle, tx_start high the next cycle with tx_byte=8'h41; after tx_done_tick, busy=0 and rr_ptr=1.
2. Round robin, all requesters always valid with last=1: valid=4'b1111, data i=8'h30+i -> grants in order 0,1,2,3,0; bytes 30,31,32,33,30.
3. Packet lock: req0 sends 3 bytes AA,BB,CC with last on CC while req1 is constantly valid -> serializer sees AA,BB,CC before req1's byte; req_ready[1]=0 throughout.
4. Back-to-back timing: tx_done_tick in cycle D with req2 valid -> req_ready[2]=1 in D+1 and tx_start in D+2; tx_byte is unchanged from tx_start until tx_done_tick.
5. Reset mid-byte: assert reset in WAIT -> next cycle all outputs at reset values; a stray tx_done_tick afterwards produces no tx_start.
6. HOLD_TIMEOUT_EN with HOLD_TIMEOUT=16: req0 sends a first byte with last=0, then drops valid -> exactly 16 cycles after HOLD entry timeout_err pulses once and req1 is then granted. Without the macro, the same stall leaves state in HOLD and timeout_err=0.
